irq_conditioner: RTL and testbench

IRQ_CONDITIONER -- requirements
Module: irq_conditioner

---
 rtl/irq_conditioner_if.sv | 33 +++
 rtl/irq_conditioner.sv | 124 ++++++++++++
 tb/tb_irq_conditioner.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_conditioner_if.sv
// irq_conditioner_if
// Configuration bus for the interrupt conditioner.
// Signals:
//   i_cfg_we    - write strobe; the register selected by i_cfg_addr
//                 is written at the next rising edge
//   i_cfg_addr  - register address (0 MASK, 1 FLT, 2 status, 3 reserved)
//   i_cfg_data  - write data
//   o_cfg_rdata - registered read data for the address presented on
//                 the previous cycle
// Modports:
//   master - the side that issues register accesses
//   slave  - the conditioner

interface irq_conditioner_if;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_addr;
    logic [31:0] i_cfg_data;
    logic [31:0] o_cfg_rdata;

    modport master (
        output i_cfg_we,
        output i_cfg_addr,
        output i_cfg_data,
        input  o_cfg_rdata
    );

    modport slave (
        input  i_cfg_we,
        input  i_cfg_addr,
        input  i_cfg_data,
        output o_cfg_rdata
    );
endinterface

// File: rtl/irq_conditioner.sv
// irq_conditioner
// Conditions asynchronous external interrupt pins for the VIC.
// Each line is synchronized by two flops, then passed through a
// programmable glitch filter. The filtered level is masked and
// registered onto o_ext.
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset
//   i_irq_raw - raw asynchronous interrupt pins, N_LINES wide
//   cfg       - configuration bus (slave modport of irq_conditioner_if)
//   o_ext     - conditioned lines, registered, drive VIC i_ext directly
// Register map (N_LINES must not exceed 32):
//   0 MASK   (rw, reset all ones)
//   1 FLT    (rw, reset FLT_RST) filter length in cycles
//   2 STATUS (ro) unmasked filtered levels
//   3 reads as zero, writes ignored

module irq_conditioner #(
    parameter int N_LINES = 31,
    parameter int FLT_W   = 4,
    parameter int FLT_RST = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] i_irq_raw,
    irq_conditioner_if.slave   cfg,
    output logic [N_LINES-1:0] o_ext
);

    logic [N_LINES-1:0] s1;
    logic [N_LINES-1:0] s2;
    logic [N_LINES-1:0] f;
    logic [FLT_W-1:0]   cnt [N_LINES];
    logic [N_LINES-1:0] mask;
    logic [FLT_W-1:0]   flt;

    logic [N_LINES-1:0] f_nxt;
    logic [FLT_W-1:0]   cnt_nxt [N_LINES];
    logic [N_LINES-1:0] mask_nxt;
    logic [FLT_W-1:0]   flt_nxt;
    logic [31:0]        rd_mux;

    // Upper write-data bits beyond the register widths carry no meaning.
    logic unused_cfg_data;
    assign unused_cfg_data = ^cfg.i_cfg_data;

    // Glitch filter next state for every line. The count is widened by
    // one bit before the compare so cnt+1 can never wrap; a line only
    // flips once it has disagreed with f for FLT consecutive cycles
    // (FLT of 0 or 1 flips on the first disagreeing cycle). Shrinking
    // FLT below a running count resolves on the next disagreeing cycle
    // because of the >= compare.
    always_comb begin
        f_nxt = f;
        for (int n = 0; n < N_LINES; n++) begin
            cnt_nxt[n] = '0;
            if (s2[n] != f[n]) begin
                if (({1'b0, cnt[n]} + 1'b1) >= {1'b0, flt}) begin
                    f_nxt[n] = s2[n];
                end else begin
                    cnt_nxt[n] = cnt[n] + 1'b1;
                end
            end
        end
    end

    // Configuration writes. The new MASK is used when forming o_ext at
    // the same edge it is written, so a mask change shows on o_ext one
    // edge after the write is presented. The new FLT is only used for
    // compares from the following edge onwards.
    always_comb begin
        mask_nxt = mask;
        flt_nxt  = flt;
        if (cfg.i_cfg_we) begin
            case (cfg.i_cfg_addr)
                2'd0:    mask_nxt = cfg.i_cfg_data[N_LINES-1:0];
                2'd1:    flt_nxt  = cfg.i_cfg_data[FLT_W-1:0];
                default: ;
            endcase
        end
    end

    // Read mux uses current register values, so a same-cycle write to
    // the address being read returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (cfg.i_cfg_addr)
            2'd0:    rd_mux[N_LINES-1:0] = mask;
            2'd1:    rd_mux[FLT_W-1:0]   = flt;
            2'd2:    rd_mux[N_LINES-1:0] = f;
            default: rd_mux = '0;
        endcase
    end

    // All state. o_ext is loaded from the next filter and mask values so
    // it always equals f & MASK after every edge, adding no latency on
    // top of the filter and with no path from i_irq_raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1              <= '0;
            s2              <= '0;
            f               <= '0;
            mask            <= '1;
            flt             <= FLT_W'(FLT_RST);
            o_ext           <= '0;
            cfg.o_cfg_rdata <= '0;
            for (int n = 0; n < N_LINES; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            s1              <= i_irq_raw;
            s2              <= s1;
            f               <= f_nxt;
            mask            <= mask_nxt;
            flt             <= flt_nxt;
            o_ext           <= f_nxt & mask_nxt;
            cfg.o_cfg_rdata <= rd_mux;
            for (int n = 0; n < N_LINES; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
        end
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// tb_irq_conditioner
// Self-checking bench for irq_conditioner. Directed scenarios cover
// reset, filter latency, pulse rejection, masking, live FLT changes,
// reset during a count and all lines switching together; a randomized
// phase follows. Every cycle o_ext and o_cfg_rdata are compared with a
// behavioural model that tracks, per line, how long the synchronized
// input has disagreed with the filtered level.

module tb_irq_conditioner;

    localparam int N   = 31;
    localparam int FRST = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_raw;
    logic [N-1:0] o_ext;

    irq_conditioner_if cfg_bus ();

    irq_conditioner #(
        .N_LINES (N),
        .FLT_W   (4),
        .FLT_RST (FRST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_irq_raw (irq_raw),
        .cfg       (cfg_bus.slave),
        .o_ext     (o_ext)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model state: the pin value seen two edges ago, the
    // filtered level, how many cycles each line has disagreed, config.
    bit [N-1:0] pinDelay [2];
    bit [N-1:0] mLevel;
    int         mRun [N];
    bit [N-1:0] mMask;
    int         mFlt;
    bit [31:0]  mRdata;
    bit [N-1:0] mExt;

    // Single comparison point: counts the vector, reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at t=%0t: got 0x%08h, expected 0x%08h",
                     tag, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the values presented
    // before that edge.
    task automatic modelStep(input bit r, input bit [N-1:0] raw, input bit we,
                             input bit [1:0] addr, input bit [31:0] data);
        bit [N-1:0] seen;
        int need;
        if (r) begin
            pinDelay[0] = '0;
            pinDelay[1] = '0;
            mLevel      = '0;
            for (int n = 0; n < N; n++) mRun[n] = 0;
            mMask  = '1;
            mFlt   = FRST;
            mRdata = 0;
            mExt   = '0;
        end else begin
            case (addr)
                2'd0:    mRdata = {1'b0, mMask};
                2'd1:    mRdata = 32'(mFlt);
                2'd2:    mRdata = {1'b0, mLevel};
                default: mRdata = 0;
            endcase
            seen = pinDelay[1];
            need = (mFlt < 1) ? 1 : mFlt;
            for (int n = 0; n < N; n++) begin
                if (seen[n] == mLevel[n]) begin
                    mRun[n] = 0;
                end else begin
                    mRun[n] = mRun[n] + 1;
                    if (mRun[n] >= need) begin
                        mLevel[n] = seen[n];
                        mRun[n]   = 0;
                    end
                end
            end
            pinDelay[1] = pinDelay[0];
            pinDelay[0] = raw;
            if (we && addr == 2'd0) mMask = data[N-1:0];
            if (we && addr == 2'd1) mFlt  = int'(data[3:0]);
            mExt = mLevel & mMask;
        end
    endtask

    // Drive one cycle of inputs, clock it into DUT and model, then
    // compare both outputs shortly after the edge.
    task automatic applyStimulus(input bit r, input bit [N-1:0] raw,
                                 input bit we, input bit [1:0] addr,
                                 input bit [31:0] data);
        rst                = r;
        irq_raw            = raw;
        cfg_bus.i_cfg_we   = we;
        cfg_bus.i_cfg_addr = addr;
        cfg_bus.i_cfg_data = data;
        @(posedge clk);
        modelStep(r, raw, we, addr, data);
        #1;
        checkOutput("o_ext", {1'b0, o_ext}, {1'b0, mExt});
        checkOutput("o_cfg_rdata", cfg_bus.o_cfg_rdata, mRdata);
    endtask

    initial begin
        bit [N-1:0] raw;
        bit [N-1:0] prevExt;
        bit [N-1:0] lastExt;
        int idx;
        int highs;
        int steps;
        bit [1:0] a;
        bit [31:0] d;

        rst                = 1'b1;
        irq_raw            = '0;
        cfg_bus.i_cfg_we   = 1'b0;
        cfg_bus.i_cfg_addr = '0;
        cfg_bus.i_cfg_data = '0;
        pinDelay[0] = '0;
        pinDelay[1] = '0;
        mLevel = '0;
        mMask  = '1;
        mFlt   = FRST;
        mRdata = 0;
        mExt   = '0;
        for (int n = 0; n < N; n++) mRun[n] = 0;

        // Reset wins over a concurrent FLT write.
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 1, 2'd1, 32'h7);
        checkOutput("rst_ext", {1'b0, o_ext}, 32'h0);
        checkOutput("rst_rdata", cfg_bus.o_cfg_rdata, 32'h0);
        applyStimulus(0, '0, 0, 2'd1, 0);
        checkOutput("rst_flt_read", cfg_bus.o_cfg_rdata, 32'h2);

        // raw[1] rises and holds: with FLT=2 it reaches o_ext on the
        // fourth edge counting the capture edge.
        raw = '0;
        raw[1] = 1'b1;
        idx = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, raw, 0, 2'd1, 0);
            if (o_ext[1] && idx == 0) idx = i;
        end
        checkOutput("lat_flt2", idx, 4);

        // FLT=4: a 3-cycle pulse on raw[8] is rejected, a 4-cycle pulse
        // passes with its width preserved.
        applyStimulus(0, raw, 1, 2'd1, 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(0, raw, 0, 2'd0, 0);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            raw[8] = (i < 3);
            applyStimulus(0, raw, 0, 2'd2, 0);
            if (o_ext[8]) highs++;
        end
        checkOutput("short_pulse", highs, 0);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            raw[8] = (i < 4);
            applyStimulus(0, raw, 0, 2'd2, 0);
            if (o_ext[8]) highs++;
        end
        checkOutput("long_pulse_len", highs, 4);

        // Mask lines 2 and 8 while asserted; status still shows them.
        raw[2] = 1'b1;
        raw[8] = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(0, raw, 0, 2'd2, 0);
        checkOutput("pre_mask", {1'b0, o_ext} & 32'h104, 32'h104);
        applyStimulus(0, raw, 1, 2'd0, 32'h7FFF_FEFB);
        checkOutput("mask_drop", {1'b0, o_ext} & 32'h104, 32'h0);
        applyStimulus(0, raw, 0, 2'd2, 0);
        checkOutput("status_bits", cfg_bus.o_cfg_rdata & 32'h104, 32'h104);
        applyStimulus(0, raw, 1, 2'd0, 32'hFFFF_FFFF);
        checkOutput("unmask", {1'b0, o_ext} & 32'h104, 32'h104);

        // FLT=15, raw[3] rises; shrinking FLT to 1 mid-count resolves
        // one edge after the write.
        applyStimulus(0, raw, 1, 2'd1, 32'd15);
        raw[3] = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, raw, 0, 2'd1, 0);
        applyStimulus(0, raw, 1, 2'd1, 32'd1);
        checkOutput("flt_shrink_hold", {31'b0, o_ext[3]}, 32'h0);
        applyStimulus(0, raw, 0, 2'd1, 0);
        checkOutput("flt_shrink_flip", {31'b0, o_ext[3]}, 32'h1);

        // Reset mid-count on raw[5], held high through release.
        applyStimulus(0, raw, 1, 2'd1, 32'd6);
        raw[5] = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, raw, 0, 2'd2, 0);
        applyStimulus(1, raw, 0, 2'd2, 0);
        applyStimulus(1, raw, 0, 2'd2, 0);
        checkOutput("mid_rst_ext", {1'b0, o_ext}, 32'h0);
        idx = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, raw, 0, 2'd2, 0);
            if (o_ext[5] && idx == 0) idx = i;
        end
        checkOutput("rst_release", idx, FRST + 2);

        // All lines switch on the same cycle with FLT=3.
        applyStimulus(0, '0, 1, 2'd1, 32'd3);
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 2'd0, 0);
        prevExt = o_ext;
        lastExt = o_ext;
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, '1, 0, 2'd2, 0);
            if (o_ext != prevExt) begin
                steps++;
                lastExt = o_ext;
            end
            prevExt = o_ext;
        end
        checkOutput("all_lines_steps", steps, 1);
        checkOutput("all_lines_val", {1'b0, lastExt}, 32'h7FFF_FFFF);

        // Randomized phase: sparse pin toggles, occasional config writes
        // and rare resets.
        raw = '1;
        for (int i = 0; i < 400; i++) begin
            raw = raw ^ N'($urandom & $urandom & $urandom);
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : ($urandom | $urandom);
            applyStimulus(($urandom_range(0, 99) == 0), raw,
                          ($urandom_range(0, 7) == 0), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
